pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 77 +++++++
 tb/tb_pipe_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector, one-cycle flush/redirect,
// saturating stall-cycle counter and a sticky stall watchdog.
module pipe_ctrl #(
  parameter int unsigned WDOG_LIMIT = 255,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             flush_req,
  input  logic [31:0]      flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             timeout
);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } state_t;

  localparam logic [15:0] WDOG_MAX = 16'(WDOG_LIMIT);

  state_t      state;
  logic [15:0] wdog;
  logic        stall_any;
  logic        any_req;

  assign any_req   = stallreq_id | stallreq_ex | stallreq_mem;
  assign stall_any = |stall;

  // A deeper stage stalling must also freeze every stage in front of it.
  always_comb begin
    stall = 6'b000000;
    if (state != FLUSH) begin
      if (stallreq_mem)     stall = 6'b011111;
      else if (stallreq_ex) stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
    end
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // the reset branch clears everything so an aborted flush or stall leaves no trace.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      flush        <= 1'b0;
      new_pc       <= 32'h0;
      stall_cycles <= '0;
      wdog         <= 16'h0;
      timeout      <= 1'b0;
    end else begin
      if (flush_req) begin
        state  <= FLUSH;
        flush  <= 1'b1;
        new_pc <= flush_pc;
      end else begin
        state <= any_req ? STALL : RUN;
        flush <= 1'b0;
      end

      if (stall_any) begin
        if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
        if (wdog != WDOG_MAX)   wdog <= wdog + 16'd1;
        if (wdog >= WDOG_MAX - 16'd1) timeout <= 1'b1;
      end else begin
        wdog <= 16'h0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short watchdog and a 4-bit stall counter.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [3:0]  stall_cycles;
  logic        timeout;

  int nvec  = 0;
  int nfail = 0;

  pipe_ctrl #(.WDOG_LIMIT(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_cycles (stall_cycles),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nvec++;
    assert (observed === expected)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0;
    stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    flush_req = 1'b0; flush_pc = 32'h0;

    // Reset state, and stall still decoded while in reset
    #2;
    check("rst_stall",   32'(stall), 32'h00);
    check("rst_flush",   32'(flush), 32'h0);
    check("rst_new_pc",  new_pc, 32'h0);
    check("rst_cycles",  32'(stall_cycles), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    stallreq_mem = 1'b1; #1;
    check("rst_stall_mem", 32'(stall), 32'h1f);
    stallreq_mem = 1'b0;

    @(negedge clk) rst = 1'b1;

    // Stall priority, checked combinationally before any edge
    stallreq_id = 1'b1; #1;
    check("prio_id", 32'(stall), 32'h07);
    stallreq_ex = 1'b1; #1;
    check("prio_id_ex", 32'(stall), 32'h0f);
    stallreq_mem = 1'b1; #1;
    check("prio_all", 32'(stall), 32'h1f);
    stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0; #1;
    check("prio_none", 32'(stall), 32'h00);
    @(negedge clk);
    check("idle_cycles", 32'(stall_cycles), 32'h0);
    check("idle_flush",  32'(flush), 32'h0);

    // Single flush
    flush_req = 1'b1; flush_pc = 32'h0000_0040;
    @(negedge clk);
    flush_req = 1'b0;
    check("f1_flush",  32'(flush), 32'h1);
    check("f1_new_pc", new_pc, 32'h40);
    check("f1_stall",  32'(stall), 32'h00);
    @(negedge clk);
    check("f1_flush_end", 32'(flush), 32'h0);
    check("f1_pc_hold",   new_pc, 32'h40);

    // Flush together with a held MEM stall (entry edge sees stall=011111: one count)
    stallreq_mem = 1'b1; flush_req = 1'b1; flush_pc = 32'h80;
    @(negedge clk);
    flush_req = 1'b0;
    check("fs_flush",  32'(flush), 32'h1);
    check("fs_new_pc", new_pc, 32'h80);
    check("fs_stall",  32'(stall), 32'h00);
    @(negedge clk);
    check("fs_flush_end", 32'(flush), 32'h0);
    check("fs_stall_after", 32'(stall), 32'h1f);
    stallreq_mem = 1'b0;
    @(negedge clk);
    check("fs_cycles", 32'(stall_cycles), 32'h1);

    // Back-to-back flush
    flush_req = 1'b1; flush_pc = 32'h100;
    @(negedge clk);
    flush_pc = 32'h200;
    check("bb_flush1", 32'(flush), 32'h1);
    check("bb_pc1",    new_pc, 32'h100);
    @(negedge clk);
    flush_req = 1'b0;
    check("bb_flush2", 32'(flush), 32'h1);
    check("bb_pc2",    new_pc, 32'h200);
    @(negedge clk);
    check("bb_flush_end", 32'(flush), 32'h0);

    // Watchdog at limit 4
    stallreq_ex = 1'b1;
    repeat (3) @(negedge clk);
    check("wd_3", 32'(timeout), 32'h0);
    @(negedge clk);
    check("wd_4", 32'(timeout), 32'h1);
    stallreq_ex = 1'b0;
    @(negedge clk);
    check("wd_sticky", 32'(timeout), 32'h1);
    check("wd_stall",  32'(stall), 32'h00);
    check("wd_cycles", 32'(stall_cycles), 32'h5);

    // Counter saturation, then reset mid-STALL
    stallreq_ex = 1'b1;
    repeat (20) @(negedge clk);
    check("sat_cycles", 32'(stall_cycles), 32'hf);
    check("sat_stall",  32'(stall), 32'h0f);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cycles",  32'(stall_cycles), 32'h0);
    check("mid_rst_timeout", 32'(timeout), 32'h0);
    check("mid_rst_flush",   32'(flush), 32'h0);
    check("mid_rst_new_pc",  new_pc, 32'h0);
    check("mid_rst_stall",   32'(stall), 32'h0f);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("post_rst_cycles",  32'(stall_cycles), 32'h1);
    check("post_rst_timeout", 32'(timeout), 32'h0);
    stallreq_ex = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
